stack_memory: RTL

- Parametrised successor to the processor's data memory. One word-addressed RAM serves two clients: a general load/store port and a hardware stack engine.
- The stack engine owns the stack pointer (push/pop, full/empty, error flag), so the datapath no longer computes SP.
- Sits between the double-accumulator datapath and control unit. The control unit drives Push/Pop; the datapath drives Addr/Data.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/stack_ctrl.sv | 87 ++++++++
 rtl/stack_memory.sv | 93 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared widths and stack-operation encoding for stack_memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;

    // Encoding matches {Push, Pop} so decode is a plain cast
    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({push, pop});
    endfunction

endpackage

`default_nettype wire

// File: rtl/stack_ctrl.sv
// ============================================================================
// Module  : stack_ctrl
// Purpose : Stack pointer, full/empty/error flags and stack write request.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stack_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int STACK_LIMIT = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] EMPTY_SP = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FULL_SP  = ADDR_W'(STACK_LIMIT - 1);

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              err_q, err_d;
    stack_op_e         op;

    assign stack_empty = (sp_q == EMPTY_SP);
    assign stack_full  = (sp_q == FULL_SP);
    assign sp          = sp_q;
    assign stack_err   = err_q;

    always_comb begin
        op      = decode_op(push, pop);
        sp_d    = sp_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_addr = sp_q;
        wr_data = push_data;
        unique case (op)
            OP_PUSH: begin
                if (stack_full) begin
                    err_d = 1'b1;
                end else begin
                    wr_en = 1'b1;
                    sp_d  = sp_q - ADDR_W'(1);
                end
            end
            OP_POP: begin
                if (stack_empty) err_d = 1'b1;
                else             sp_d  = sp_q + ADDR_W'(1);
            end
            OP_REPLACE: begin
                // Overwrites the occupied top slot, one above the free slot
                if (stack_empty) begin
                    err_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = sp_q + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= EMPTY_SP;
            err_q <= 1'b0;
        end else begin
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stack_memory.sv
// ============================================================================
// Module  : stack_memory
// Purpose : Word RAM shared by a load/store port and a hardware stack engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stack_memory
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int STACK_LIMIT = 192
) (
    input  logic              CLK,
    input  logic              Reset_N,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data,
    input  logic              Mem_Write,
    output logic [DATA_W-1:0] Mem_Data,
    input  logic              Push,
    input  logic              Pop,
    input  logic [DATA_W-1:0] Push_Data,
    output logic [ADDR_W-1:0] SP,
    output logic [DATA_W-1:0] SP_Data,
    output logic              Stack_Empty,
    output logic              Stack_Full,
    output logic              Stack_Err
);

    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              stack_we;
    logic [ADDR_W-1:0] stack_waddr;
    logic [DATA_W-1:0] stack_wdata;

    logic              addr_in_range;
    logic              store_en;
    logic [IDX_W-1:0]  addr_idx;
    logic [IDX_W-1:0]  stack_idx;
    logic [IDX_W-1:0]  top_idx;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;

    stack_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_stack_ctrl (
        .clk         (CLK),
        .rst_n       (Reset_N),
        .push        (Push),
        .pop         (Pop),
        .push_data   (Push_Data),
        .sp          (SP),
        .stack_empty (Stack_Empty),
        .stack_full  (Stack_Full),
        .stack_err   (Stack_Err),
        .wr_en       (stack_we),
        .wr_addr     (stack_waddr),
        .wr_data     (stack_wdata)
    );

    always_comb begin
        addr_in_range = ({1'b0, Addr} < DEPTH_EXT);
        addr_idx      = Addr[IDX_W-1:0];
        stack_idx     = stack_waddr[IDX_W-1:0];
        top_idx       = SP[IDX_W-1:0] + IDX_W'(1);
        // On an address clash the stack write takes the slot
        store_en      = Mem_Write && addr_in_range && !(stack_we && (stack_waddr == Addr));
        mem_data_d    = addr_in_range ? mem[addr_idx] : '0;
        SP_Data       = Stack_Empty ? '0 : mem[top_idx];
    end

    always_ff @(posedge CLK) begin
        if (store_en) mem[addr_idx]  <= Data;
        if (stack_we) mem[stack_idx] <= stack_wdata;
    end

    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) mem_data_q <= '0;
        else          mem_data_q <= mem_data_d;
    end

    assign Mem_Data = mem_data_q;

endmodule

`default_nettype wire
